// File: rtl/cordic_sincos_tan.sv
`default_nettype none
// ============================================================================
// Module : cordic_sincos_tan
// Streaming CORDIC sin/cos (2Q15) followed by a restoring divider for tan.
// Rev    : 1.0
// ============================================================================
module cordic_sincos_tan #(
   parameter int ITER     = 16,
   parameter int GUARD    = 3,
   parameter int TAN_FRAC = 16
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        s_axis_phase_tvalid,
   input  logic [17:0] s_axis_phase_tdata,
   output logic        m_axis_dout_tvalid,
   output logic [47:0] m_axis_dout_tdata,
   output logic        m_axis_tan_tvalid,
   output logic [31:0] m_axis_tan_tdata
);
   localparam int XW  = 19 + GUARD;
   localparam int ZW  = 18 + GUARD;
   localparam int RSH = 15 - GUARD;
   localparam int DIV_STAGES = 32;

   // Constants are tabulated at 2^30 scale and rounded into the 2Q(15+GUARD) format.
   function automatic longint q30_round(input longint v);
      q30_round = (v + (longint'(1) <<< (RSH - 1))) >>> RSH;
   endfunction

   function automatic logic [31:0] atan_q30(input int i);
      case (i)
         0:  atan_q30 = 32'd843314857;
         1:  atan_q30 = 32'd497837830;
         2:  atan_q30 = 32'd263043837;
         3:  atan_q30 = 32'd133525159;
         4:  atan_q30 = 32'd67021687;
         5:  atan_q30 = 32'd33543516;
         6:  atan_q30 = 32'd16775851;
         7:  atan_q30 = 32'd8388438;
         8:  atan_q30 = 32'd4194283;
         9:  atan_q30 = 32'd2097149;
         10: atan_q30 = 32'd1048576;
         11: atan_q30 = 32'd524288;
         12: atan_q30 = 32'd262144;
         13: atan_q30 = 32'd131072;
         14: atan_q30 = 32'd65536;
         15: atan_q30 = 32'd32768;
         16: atan_q30 = 32'd16384;
         17: atan_q30 = 32'd8192;
         18: atan_q30 = 32'd4096;
         19: atan_q30 = 32'd2048;
         20: atan_q30 = 32'd1024;
         21: atan_q30 = 32'd512;
         22: atan_q30 = 32'd256;
         23: atan_q30 = 32'd128;
         default: atan_q30 = 32'd0;
      endcase
   endfunction

   localparam logic signed [XW-1:0] K_INIT   = XW'(q30_round(64'sd652032874));
   localparam logic signed [XW-1:0] RND      = XW'(1 << (GUARD - 1));
   localparam logic signed [XW-1:0] SAT_POS  = XW'(32768);
   localparam logic signed [XW-1:0] SAT_NEG  = XW'(-32768);
   localparam logic signed [18:0]   PI       = 19'sd102944;
   localparam logic signed [18:0]   PI_HALF  = 19'sd51472;
   localparam logic signed [18:0]   NPI_HALF = -19'sd51472;

   // Rounded arithmetic shift keeps the truncation bias out of the x/y chain.
   function automatic logic signed [XW-1:0] rsh(input logic signed [XW-1:0] v, input int sh);
      logic signed [XW-1:0] bias;
      bias = XW'((longint'(1) << sh) >> 1);
      rsh  = (v + bias) >>> sh;
   endfunction

   function automatic logic signed [16:0] cs_out(input logic signed [XW-1:0] v, input logic neg);
      logic signed [XW-1:0] n;
      n = neg ? -v : v;
      n = (n + RND) >>> GUARD;
      if (n > SAT_POS)      n = SAT_POS;
      else if (n < SAT_NEG) n = SAT_NEG;
      cs_out = n[16:0];
   endfunction

   logic signed [XW-1:0] x_q   [0:ITER];
   logic signed [XW-1:0] y_q   [0:ITER];
   logic signed [ZW-1:0] z_q   [0:ITER];
   logic                 v_q   [0:ITER];
   logic                 neg_q [0:ITER];

   logic signed [18:0] ph_ext;
   logic signed [18:0] z_fold;
   logic               fold;

   always_comb begin
      ph_ext = {s_axis_phase_tdata[17], s_axis_phase_tdata};
      z_fold = ph_ext;
      fold   = 1'b0;
      if (ph_ext > PI_HALF) begin
         z_fold = ph_ext - PI;
         fold   = 1'b1;
      end else if (ph_ext < NPI_HALF) begin
         z_fold = ph_ext + PI;
         fold   = 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         x_q[0]   <= '0;
         y_q[0]   <= '0;
         z_q[0]   <= '0;
         v_q[0]   <= 1'b0;
         neg_q[0] <= 1'b0;
      end else begin
         x_q[0]   <= K_INIT;
         y_q[0]   <= '0;
         z_q[0]   <= {z_fold[17:0], {GUARD{1'b0}}};
         v_q[0]   <= s_axis_phase_tvalid;
         neg_q[0] <= fold;
      end
   end

   // Stage s rotates by atan(2^-(s-1)), so the first stage covers the 45 degree step.
   for (genvar s = 1; s <= ITER; s++) begin : g_stage
      localparam int SH = s - 1;
      localparam logic signed [ZW-1:0] ATAN = ZW'(q30_round(longint'(atan_q30(SH))));
      logic signed [XW-1:0] x_sh;
      logic signed [XW-1:0] y_sh;
      assign x_sh = rsh(x_q[s-1], SH);
      assign y_sh = rsh(y_q[s-1], SH);

      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            x_q[s]   <= '0;
            y_q[s]   <= '0;
            z_q[s]   <= '0;
            v_q[s]   <= 1'b0;
            neg_q[s] <= 1'b0;
         end else begin
            v_q[s]   <= v_q[s-1];
            neg_q[s] <= neg_q[s-1];
            if (z_q[s-1][ZW-1]) begin
               x_q[s] <= x_q[s-1] + y_sh;
               y_q[s] <= y_q[s-1] - x_sh;
               z_q[s] <= z_q[s-1] + ATAN;
            end else begin
               x_q[s] <= x_q[s-1] - y_sh;
               y_q[s] <= y_q[s-1] + x_sh;
               z_q[s] <= z_q[s-1] - ATAN;
            end
         end
      end
   end

   logic signed [16:0] cos_fin;
   logic signed [16:0] sin_fin;
   assign cos_fin = cs_out(x_q[ITER], neg_q[ITER]);
   assign sin_fin = cs_out(y_q[ITER], neg_q[ITER]);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_axis_dout_tvalid <= 1'b0;
         m_axis_dout_tdata  <= '0;
      end else begin
         m_axis_dout_tvalid <= v_q[ITER];
         if (v_q[ITER])
            m_axis_dout_tdata <= {{7{sin_fin[16]}}, sin_fin, {7{cos_fin[16]}}, cos_fin};
      end
   end

   logic signed [16:0] dv_sin;
   logic signed [16:0] dv_cos;
   logic        [16:0] sin_mag;
   logic        [16:0] cos_mag;
   logic        [63:0] num;
   logic               div_ovf;

   assign dv_sin  = m_axis_dout_tdata[40:24];
   assign dv_cos  = m_axis_dout_tdata[16:0];
   assign sin_mag = dv_sin[16] ? 17'(-dv_sin) : dv_sin;
   assign cos_mag = dv_cos[16] ? 17'(-dv_cos) : dv_cos;
   assign num     = {47'd0, sin_mag} << TAN_FRAC;
   // Any quotient bit above the 32 produced ones (or cos = 0) forces saturation.
   assign div_ovf = (num[63:32] >= {15'd0, cos_mag});

   logic [17:0] r_q   [1:DIV_STAGES];
   logic [31:0] q_q   [1:DIV_STAGES];
   logic [16:0] d_q   [1:DIV_STAGES];
   logic        sg_q  [1:DIV_STAGES];
   logic        ov_q  [1:DIV_STAGES];
   logic        dvl_q [1:DIV_STAGES];

   for (genvar j = 1; j <= DIV_STAGES; j++) begin : g_div
      logic [17:0] r_in;
      logic [31:0] q_in;
      logic [16:0] d_in;
      logic        sg_in;
      logic        ov_in;
      logic        v_in;
      logic [17:0] r_sh;
      logic        ge;

      if (j == 1) begin : g_src
         assign r_in  = div_ovf ? 18'd0 : num[49:32];
         assign q_in  = num[31:0];
         assign d_in  = cos_mag;
         assign sg_in = dv_sin[16] ^ dv_cos[16];
         assign ov_in = div_ovf;
         assign v_in  = m_axis_dout_tvalid;
      end else begin : g_src
         assign r_in  = r_q[j-1];
         assign q_in  = q_q[j-1];
         assign d_in  = d_q[j-1];
         assign sg_in = sg_q[j-1];
         assign ov_in = ov_q[j-1];
         assign v_in  = dvl_q[j-1];
      end

      assign r_sh = {r_in[16:0], q_in[31]};
      assign ge   = (r_sh >= {1'b0, d_in});

      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            r_q[j]   <= '0;
            q_q[j]   <= '0;
            d_q[j]   <= '0;
            sg_q[j]  <= 1'b0;
            ov_q[j]  <= 1'b0;
            dvl_q[j] <= 1'b0;
         end else begin
            r_q[j]   <= ge ? (r_sh - {1'b0, d_in}) : r_sh;
            q_q[j]   <= {q_in[30:0], ge};
            d_q[j]   <= d_in;
            sg_q[j]  <= sg_in;
            ov_q[j]  <= ov_in;
            dvl_q[j] <= v_in;
         end
      end
   end

   logic [31:0] tan_mag;
   assign tan_mag = (ov_q[DIV_STAGES] || q_q[DIV_STAGES][31]) ? 32'h7FFF_FFFF : q_q[DIV_STAGES];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_axis_tan_tvalid <= 1'b0;
         m_axis_tan_tdata  <= '0;
      end else begin
         m_axis_tan_tvalid <= dvl_q[DIV_STAGES];
         if (dvl_q[DIV_STAGES])
            m_axis_tan_tdata <= sg_q[DIV_STAGES] ? -tan_mag : tan_mag;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_cordic_sincos_tan.sv
`default_nettype none
// ============================================================================
// Module : tb_cordic_sincos_tan
// Directed table, streamed sweep against a real-math model, mid-stream reset.
// Rev    : 1.0
// ============================================================================
module tb_cordic_sincos_tan;
   localparam int LAT_CS  = 18;
   localparam int LAT_TAN = 51;
   localparam int HN      = 4096;
   localparam int NV      = 7;

   logic        aclk     = 1'b0;
   logic        aresetn  = 1'b0;
   logic        in_valid = 1'b0;
   logic [17:0] in_data  = '0;
   logic        dout_valid;
   logic [47:0] dout_data;
   logic        tan_valid;
   logic [31:0] tan_data;

   cordic_sincos_tan #(.ITER(16), .GUARD(3), .TAN_FRAC(16)) dut (
      .aclk                (aclk),
      .aresetn             (aresetn),
      .s_axis_phase_tvalid (in_valid),
      .s_axis_phase_tdata  (in_data),
      .m_axis_dout_tvalid  (dout_valid),
      .m_axis_dout_tdata   (dout_data),
      .m_axis_tan_tvalid   (tan_valid),
      .m_axis_tan_tdata    (tan_data)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [17:0] phase;
      int          cos_e;
      int          sin_e;
      longint      tan_e;
      longint      tan_tol;
      bit          tan_sat;
   } vec_t;

   vec_t        vecs [NV];
   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   bit          hv [HN];
   logic [17:0] hp [HN];
   logic [47:0] last_dout = '0;
   logic [31:0] last_tan  = '0;

   function automatic longint labs(input longint v);
      labs = (v < 0) ? -v : v;
   endfunction

   function automatic real rabs(input real v);
      rabs = (v < 0.0) ? -v : v;
   endfunction

   function automatic real phase_rad(input logic [17:0] ph);
      phase_rad = real'($signed(ph)) / 32768.0;
   endfunction

   // Ideal rounded 2Q15 sin or cos, clamped to +-1.0.
   function automatic int ideal_cs(input logic [17:0] ph, input bit want_sin);
      real v;
      int  r;
      v = want_sin ? $sin(phase_rad(ph)) : $cos(phase_rad(ph));
      v = v * 32768.0;
      r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
      if (r > 32768)  r = 32768;
      if (r < -32768) r = -32768;
      ideal_cs = r;
   endfunction

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic check_outputs();
      int  ic, it, ci, si, ce, se;
      bit  ev_cs, ev_tan;
      real c, s, te, tol;
      longint ta;
      ic     = cyc - LAT_CS;
      it     = cyc - LAT_TAN;
      ev_cs  = (ic >= 0) ? hv[ic % HN] : 1'b0;
      ev_tan = (it >= 0) ? hv[it % HN] : 1'b0;

      chk(dout_valid == ev_cs, "dout_tvalid", longint'(dout_valid), longint'(ev_cs));
      if (ev_cs) begin
         ci = int'($signed(dout_data[23:0]));
         si = int'($signed(dout_data[47:24]));
         ce = ideal_cs(hp[ic % HN], 1'b0);
         se = ideal_cs(hp[ic % HN], 1'b1);
         chk(labs(longint'(ci - ce)) <= 2, "cos_model", ci, ce);
         chk(labs(longint'(si - se)) <= 2, "sin_model", si, se);
         last_dout = dout_data;
      end else begin
         chk(dout_data == last_dout, "dout_hold", longint'(dout_data), longint'(last_dout));
      end

      chk(tan_valid == ev_tan, "tan_tvalid", longint'(tan_valid), longint'(ev_tan));
      if (ev_tan) begin
         c = $cos(phase_rad(hp[it % HN])) * 32768.0;
         s = $sin(phase_rad(hp[it % HN])) * 32768.0;
         if (rabs(c) >= 1024.0) begin
            te  = s / c * 65536.0;
            tol = (2.5 / rabs(c) + 2.5 * rabs(s) / (c * c)) * 65536.0 + 4.0;
            ta  = longint'($signed(tan_data));
            chk(rabs(real'(ta) - te) <= tol, "tan_model", ta, $rtoi(te));
         end
         last_tan = tan_data;
      end else begin
         chk(tan_data == last_tan, "tan_hold", longint'(tan_data), longint'(last_tan));
      end
   endtask

   task automatic tick(input bit v, input logic [17:0] ph);
      @(posedge aclk);
      #1;
      cyc++;
      hv[cyc % HN] = v;
      hp[cyc % HN] = ph;
      in_valid     = v;
      in_data      = ph;
      @(negedge aclk);
      check_outputs();
   endtask

   task automatic clear_history();
      for (int i = 0; i < HN; i++) hv[i] = 1'b0;
      last_dout = '0;
      last_tan  = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [17:0] ph;
      int          ci, si;
      longint      ta;

      vecs[0] = '{18'd0,             32768,      0,      0,   16, 1'b0};
      vecs[1] = '{18'd25736,         23170,  23170,  65536,  256, 1'b0};
      vecs[2] = '{18'd98304,        -32440,   4624,  -9342,  256, 1'b0};
      vecs[3] = '{18'(-51472),           0, -32768,      0,    0, 1'b1};
      vecs[4] = '{18'(-98304),      -32440,  -4624,   9342,  256, 1'b0};
      vecs[5] = '{18'd51472,             0,  32768,      0,    0, 1'b1};
      vecs[6] = '{18'h20000,        -21418,  24799, -75879,  256, 1'b0};

      clear_history();
      for (int n = 0; n < 4; n++) tick(1'b0, 18'd0);
      chk(dout_valid == 1'b0, "reset_dout_tvalid", longint'(dout_valid), 0);
      chk(dout_data == '0,    "reset_dout_tdata",  longint'(dout_data), 0);
      chk(tan_valid == 1'b0,  "reset_tan_tvalid",  longint'(tan_valid), 0);
      chk(tan_data == '0,     "reset_tan_tdata",   longint'(tan_data), 0);
      aresetn = 1'b1;

      for (int k = 0; k < NV; k++) begin
         tick(1'b1, vecs[k].phase);
         for (int n = 1; n <= 55; n++) begin
            tick(1'b0, 18'd0);
            if (n == LAT_CS) begin
               ci = int'($signed(dout_data[23:0]));
               si = int'($signed(dout_data[47:24]));
               chk(dout_valid == 1'b1, "vec_dout_tvalid", longint'(dout_valid), 1);
               chk(labs(longint'(ci - vecs[k].cos_e)) <= 2, "vec_cos", ci, vecs[k].cos_e);
               chk(labs(longint'(si - vecs[k].sin_e)) <= 2, "vec_sin", si, vecs[k].sin_e);
            end
            if (n == LAT_TAN) begin
               ta = longint'($signed(tan_data));
               chk(tan_valid == 1'b1, "vec_tan_tvalid", longint'(tan_valid), 1);
               if (vecs[k].tan_sat)
                  chk(labs(ta) >= 64'h7F00_0000, "vec_tan_sat", ta, 64'h7FFF_FFFF);
               else
                  chk(labs(ta - vecs[k].tan_e) <= vecs[k].tan_tol, "vec_tan", ta, vecs[k].tan_e);
            end
         end
      end

      ph = 18'h20000;
      for (int n = 0; n < 700; n++) begin
         tick($urandom_range(0, 3) != 0, ph);
         ph = ph + 18'd1237;
      end
      for (int n = 0; n < 150; n++)
         tick($urandom_range(0, 2) != 0, 18'($urandom_range(0, 262143)));
      for (int n = 0; n < 55; n++) tick(1'b0, 18'd0);

      for (int n = 0; n < 40; n++)
         tick($urandom_range(0, 3) != 0, 18'($urandom_range(0, 262143)));
      #2;
      aresetn = 1'b0;
      #1;
      chk(dout_valid == 1'b0, "midreset_dout_tvalid", longint'(dout_valid), 0);
      chk(dout_data == '0,    "midreset_dout_tdata",  longint'(dout_data), 0);
      chk(tan_valid == 1'b0,  "midreset_tan_tvalid",  longint'(tan_valid), 0);
      chk(tan_data == '0,     "midreset_tan_tdata",   longint'(tan_data), 0);
      clear_history();
      for (int n = 0; n < 3; n++) tick(1'b0, 18'd0);
      aresetn = 1'b1;
      for (int n = 0; n < 60; n++) tick(1'b0, 18'd0);
      for (int n = 0; n < 5; n++) tick(1'b1, 18'(n * 20011));
      for (int n = 0; n < 60; n++) tick(1'b0, 18'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
